// File: rtl/sram_ctrl.sv
// Word-wide controller for an external asynchronous 512Kx16 SRAM.
// Each CPU access runs as a registered multi-cycle transaction closed by a one-cycle ack.
module sram_ctrl #(
    parameter int                        ADDR_W      = 14,
    parameter int                        SRAM_AW     = 19,
    parameter logic [SRAM_AW-ADDR_W-1:0] BANK        = '0,
    parameter int                        WAIT_STATES = 0
) (
    input  logic               clk_cpu,
    input  logic               rst,
    input  logic               req,
    input  logic               w_en,
    input  logic [ADDR_W-1:0]  A_data,
    input  logic [15:0]        D_out,
    output logic [15:0]        D_in,
    output logic               ack,
    output logic               busy,
    output logic [SRAM_AW-1:0] sram_a,
    output logic [15:0]        sram_d_o,
    output logic               sram_d_oe,
    input  logic [15:0]        sram_d_i,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_lb_n,
    output logic               sram_ub_n
);

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    typedef enum logic [2:0] {
        IDLE,
        RD_ACC,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [15:0]        din_q, din_d;
    logic               ack_q, ack_d;
    logic               busy_q, busy_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [15:0]        dout_q, dout_d;
    logic               doe_q, doe_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;

    // Pin values are computed for the state being entered, so every pin is a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        din_d   = din_q;
        ack_d   = 1'b0;
        addr_d  = addr_q;
        dout_d  = dout_q;
        doe_d   = doe_q;
        ce_n_d  = ce_n_q;
        oe_n_d  = oe_n_q;
        we_n_d  = we_n_q;

        case (state_q)
            IDLE: begin
                ce_n_d = 1'b1;
                oe_n_d = 1'b1;
                we_n_d = 1'b1;
                doe_d  = 1'b0;
                // The ack cycle ignores req so a req held one cycle too long never re-issues.
                if (req && !ack_q) begin
                    addr_d = {BANK, A_data};
                    ce_n_d = 1'b0;
                    if (w_en) begin
                        dout_d  = D_out;
                        doe_d   = 1'b1;
                        state_d = WR_SETUP;
                    end else begin
                        oe_n_d  = 1'b0;
                        cnt_d   = WS;
                        state_d = RD_ACC;
                    end
                end
            end
            RD_ACC: begin
                if (cnt_q == 3'd0) begin
                    din_d   = sram_d_i;
                    ack_d   = 1'b1;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            WR_SETUP: begin
                we_n_d  = 1'b0;
                cnt_d   = WS;
                state_d = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt_q == 3'd0) begin
                    we_n_d  = 1'b1;
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            WR_HOLD: begin
                ack_d   = 1'b1;
                doe_d   = 1'b0;
                ce_n_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                ce_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                we_n_d  = 1'b1;
                doe_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_cpu) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            din_q   <= 16'h0000;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            dout_q  <= 16'h0000;
            doe_q   <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            doe_q   <= doe_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
        end
    end

    assign D_in      = din_q;
    assign ack       = ack_q;
    assign busy      = busy_q;
    assign sram_a    = addr_q;
    assign sram_d_o  = dout_q;
    assign sram_d_oe = doe_q;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;
    // Byte lanes are always both enabled together with chip enable.
    assign sram_lb_n = ce_n_q;
    assign sram_ub_n = ce_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Testbench for sram_ctrl: two instances (W=0 and W=2) against an SRAM model and a
// transaction-level reference of latency, strobe timing and memory contents.
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_s      [2];
    logic        w_en_s     [2];
    logic [13:0] a_s        [2];
    logic [15:0] d_s        [2];
    logic [15:0] din_s      [2];
    logic        ack_s      [2];
    logic        busy_s     [2];
    logic [18:0] sram_a_s   [2];
    logic [15:0] sram_d_o_s [2];
    logic        d_oe_s     [2];
    logic [15:0] sram_d_i_s [2];
    logic        ce_n_s     [2];
    logic        oe_n_s     [2];
    logic        we_n_s     [2];
    logic        lb_n_s     [2];
    logic        ub_n_s     [2];

    int checks   = 0;
    int failures = 0;
    int ack_cnt  [2] = '{0, 0};
    int viol     [2] = '{0, 0};
    int ws       [2] = '{0, 2};
    logic [4:0]  bank [2] = '{5'h03, 5'h1A};

    logic [15:0] mem    [int];
    logic [15:0] shadow [int];

    always #5 clk = ~clk;

    sram_ctrl #(.ADDR_W(14), .SRAM_AW(19), .BANK(5'h03), .WAIT_STATES(0)) u_dut0 (
        .clk_cpu(clk), .rst(rst), .req(req_s[0]), .w_en(w_en_s[0]), .A_data(a_s[0]),
        .D_out(d_s[0]), .D_in(din_s[0]), .ack(ack_s[0]), .busy(busy_s[0]),
        .sram_a(sram_a_s[0]), .sram_d_o(sram_d_o_s[0]), .sram_d_oe(d_oe_s[0]),
        .sram_d_i(sram_d_i_s[0]), .sram_ce_n(ce_n_s[0]), .sram_oe_n(oe_n_s[0]),
        .sram_we_n(we_n_s[0]), .sram_lb_n(lb_n_s[0]), .sram_ub_n(ub_n_s[0]));

    sram_ctrl #(.ADDR_W(14), .SRAM_AW(19), .BANK(5'h1A), .WAIT_STATES(2)) u_dut1 (
        .clk_cpu(clk), .rst(rst), .req(req_s[1]), .w_en(w_en_s[1]), .A_data(a_s[1]),
        .D_out(d_s[1]), .D_in(din_s[1]), .ack(ack_s[1]), .busy(busy_s[1]),
        .sram_a(sram_a_s[1]), .sram_d_o(sram_d_o_s[1]), .sram_d_oe(d_oe_s[1]),
        .sram_d_i(sram_d_i_s[1]), .sram_ce_n(ce_n_s[1]), .sram_oe_n(oe_n_s[1]),
        .sram_we_n(we_n_s[1]), .sram_lb_n(lb_n_s[1]), .sram_ub_n(ub_n_s[1]));

    function automatic int key(input int k, input logic [18:0] a);
        return (k << 20) | int'(a);
    endfunction

    function automatic logic [15:0] shadow_rd(input int k, input logic [18:0] a);
        return shadow.exists(key(k, a)) ? shadow[key(k, a)] : 16'hDEAD;
    endfunction

    // SRAM model: drives read data mid-cycle, stores data on edges while written
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!ce_n_s[k] && !oe_n_s[k])
                sram_d_i_s[k] = mem.exists(key(k, sram_a_s[k])) ? mem[key(k, sram_a_s[k])] : 16'hDEAD;
            else
                sram_d_i_s[k] = 16'hDEAD;
            if (ack_s[k] === 1'b1) ack_cnt[k]++;
            if ((oe_n_s[k] === 1'b0 && d_oe_s[k] === 1'b1) ||
                lb_n_s[k] !== ce_n_s[k] || ub_n_s[k] !== ce_n_s[k]) viol[k]++;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++)
            if (we_n_s[k] === 1'b0 && ce_n_s[k] === 1'b0 && d_oe_s[k] === 1'b1)
                mem[key(k, sram_a_s[k])] = sram_d_o_s[k];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One complete transaction on instance k, checked against the timing rules.
    task automatic txn(input int k, input bit we, input logic [13:0] a,
                       input logic [15:0] d, input bit hold);
        int          edges, welow, doe_hi, acks0;
        bit          got;
        logic [15:0] din_before, exp_din;
        logic [18:0] full;
        full       = {bank[k], a};
        din_before = din_s[k];
        exp_din    = we ? din_before : shadow_rd(k, full);
        acks0      = ack_cnt[k];
        @(negedge clk);
        req_s[k] = 1'b1; w_en_s[k] = we; a_s[k] = a; d_s[k] = d;
        edges = 0; welow = 0; doe_hi = 0; got = 1'b0;
        while (!got && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1) begin
                chk("sram_a", 32'(sram_a_s[k]), 32'(full));
                chk("busy_on", 32'(busy_s[k]), 32'd1);
            end
            if (we_n_s[k] === 1'b0) welow++;
            if (d_oe_s[k] === 1'b1) doe_hi++;
            if (ack_s[k] === 1'b1) got = 1'b1;
        end
        chk("ack_seen", 32'(got), 32'd1);
        chk(we ? "wr_latency" : "rd_latency", 32'(edges), 32'(we ? 4 + ws[k] : 2 + ws[k]));
        chk("we_low_cycles", 32'(welow), 32'(we ? 1 + ws[k] : 0));
        chk("doe_cycles", 32'(doe_hi), 32'(we ? 3 + ws[k] : 0));
        chk("busy_at_ack", 32'(busy_s[k]), 32'd0);
        chk(we ? "din_kept" : "din_read", 32'(din_s[k]), 32'(exp_din));
        if (we) shadow[key(k, full)] = d;
        if (!hold) req_s[k] = 1'b0;
        @(posedge clk); #1;
        chk("ack_one_cycle", 32'(ack_s[k]), 32'd0);
        chk("no_reissue", 32'(busy_s[k]), 32'd0);
        chk("ack_count", 32'(ack_cnt[k] - acks0), 32'd1);
        chk("no_overlap", 32'(viol[k]), 32'd0);
        if (hold) begin
            req_s[k] = 1'b0;
            @(posedge clk); #1;
            chk("idle_after_hold", 32'(busy_s[k]), 32'd0);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            req_s[k] = 1'b0; w_en_s[k] = 1'b0; a_s[k] = '0; d_s[k] = '0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_ce_n", 32'(ce_n_s[k]), 32'd1);
            chk("rst_oe_n", 32'(oe_n_s[k]), 32'd1);
            chk("rst_we_n", 32'(we_n_s[k]), 32'd1);
            chk("rst_lb_ub", 32'({lb_n_s[k], ub_n_s[k]}), 32'd3);
            chk("rst_d_oe", 32'(d_oe_s[k]), 32'd0);
            chk("rst_ack", 32'(ack_s[k]), 32'd0);
            chk("rst_busy", 32'(busy_s[k]), 32'd0);
            chk("rst_din", 32'(din_s[k]), 32'd0);
            chk("rst_sram_a", 32'(sram_a_s[k]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Directed read with preloaded SRAM contents
        mem[key(0, 19'h0C123)]    = 16'hBEEF;
        shadow[key(0, 19'h0C123)] = 16'hBEEF;
        txn(0, 1'b0, 14'h0123, 16'h0000, 1'b0);

        // Write then read back at the top address, both wait-state settings
        for (int k = 0; k < 2; k++) begin
            txn(k, 1'b1, 14'h3FFF, 16'hA55A, 1'b0);
            txn(k, 1'b0, 14'h3FFF, 16'h0000, 1'b0);
        end

        // req held through the ack cycle, then re-raised after one low cycle
        for (int k = 0; k < 2; k++) begin
            txn(k, 1'b0, 14'h0123, 16'h0000, 1'b1);
            txn(k, 1'b1, 14'h0200, 16'h1234, 1'b1);
            txn(k, 1'b0, 14'h0200, 16'h0000, 1'b0);
        end

        // Reset during the second cycle of the write pulse (W=2 instance)
        begin
            int acks0;
            acks0 = ack_cnt[1];
            @(negedge clk);
            req_s[1] = 1'b1; w_en_s[1] = 1'b1; a_s[1] = 14'h0777; d_s[1] = 16'hC0DE;
            repeat (3) @(posedge clk);
            #1;
            chk("pulse_we_low", 32'(we_n_s[1]), 32'd0);
            rst = 1'b1;
            req_s[1] = 1'b0;
            @(posedge clk); #1;
            chk("abort_we_n", 32'(we_n_s[1]), 32'd1);
            chk("abort_d_oe", 32'(d_oe_s[1]), 32'd0);
            chk("abort_ce_n", 32'(ce_n_s[1]), 32'd1);
            chk("abort_ack", 32'(ack_s[1]), 32'd0);
            chk("abort_busy", 32'(busy_s[1]), 32'd0);
            @(negedge clk);
            rst = 1'b0;
            chk("abort_no_ack", 32'(ack_cnt[1] - acks0), 32'd0);
            txn(1, 1'b0, 14'h3FFF, 16'h0000, 1'b0);
        end

        // Randomized traffic over a small address window
        for (int n = 0; n < 40; n++) begin
            int          k;
            bit          we;
            logic [13:0] a;
            logic [15:0] d;
            k  = n % 2;
            we = 1'($urandom_range(0, 1));
            a  = 14'h0100 + 14'($urandom_range(0, 7));
            d  = 16'($urandom);
            txn(k, we, a, d, 1'($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
